// File: rtl/step_dir_tracker_xy.sv
// step_dir_tracker_xy: receive-side tracker for XY step/dir pulse trains.
// Keeps a saturating signed position per axis, accumulates the net step
// count of each move, and reports the per-axis delta once stepping has
// been quiet for IDLE_TICKS clk_en ticks.
module step_dir_tracker_xy #(
  parameter int POS_BITS     = 16,
  parameter int DELTA_BITS_X = 8,
  parameter int DELTA_BITS_Y = 8,
  parameter int IDLE_TICKS   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_en,
  input  logic                           step_x,
  input  logic                           dir_x,
  input  logic                           step_y,
  input  logic                           dir_y,
  input  logic                           clear,
  input  logic                           report_ready,
  output logic signed [POS_BITS-1:0]     pos_x,
  output logic signed [POS_BITS-1:0]     pos_y,
  output logic                           overflow,
  output logic                           busy,
  output logic                           report_valid,
  output logic signed [DELTA_BITS_X-1:0] delta_x,
  output logic signed [DELTA_BITS_Y-1:0] delta_y
);

  localparam int CNT_BITS = $clog2(IDLE_TICKS + 1);
  localparam logic [CNT_BITS-1:0] IDLE_LIMIT = CNT_BITS'(IDLE_TICKS);
  localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Saturating +/-1 on a position; the MSB of the result flags a clipped attempt.
  function automatic logic [POS_BITS:0] pos_step(input logic [POS_BITS-1:0] v, input logic dec);
    logic [POS_BITS-1:0] v_max;
    logic [POS_BITS-1:0] v_min;
    v_max = {1'b0, {(POS_BITS-1){1'b1}}};
    v_min = {1'b1, {(POS_BITS-1){1'b0}}};
    if (dec) begin
      if (v == v_min) return {1'b1, v};
      else            return {1'b0, v - POS_BITS'(1'b1)};
    end else begin
      if (v == v_max) return {1'b1, v};
      else            return {1'b0, v + POS_BITS'(1'b1)};
    end
  endfunction

  // Saturating +/-1 on the X move accumulator.
  function automatic logic [DELTA_BITS_X-1:0] dx_step(input logic [DELTA_BITS_X-1:0] v, input logic dec);
    logic [DELTA_BITS_X-1:0] v_max;
    logic [DELTA_BITS_X-1:0] v_min;
    v_max = {1'b0, {(DELTA_BITS_X-1){1'b1}}};
    v_min = {1'b1, {(DELTA_BITS_X-1){1'b0}}};
    if (dec) return (v == v_min) ? v : v - DELTA_BITS_X'(1'b1);
    else     return (v == v_max) ? v : v + DELTA_BITS_X'(1'b1);
  endfunction

  // Saturating +/-1 on the Y move accumulator.
  function automatic logic [DELTA_BITS_Y-1:0] dy_step(input logic [DELTA_BITS_Y-1:0] v, input logic dec);
    logic [DELTA_BITS_Y-1:0] v_max;
    logic [DELTA_BITS_Y-1:0] v_min;
    v_max = {1'b0, {(DELTA_BITS_Y-1){1'b1}}};
    v_min = {1'b1, {(DELTA_BITS_Y-1){1'b0}}};
    if (dec) return (v == v_min) ? v : v - DELTA_BITS_Y'(1'b1);
    else     return (v == v_max) ? v : v + DELTA_BITS_Y'(1'b1);
  endfunction

  logic                    r_step_x_prev;
  logic                    r_step_y_prev;
  logic [POS_BITS-1:0]     r_pos_x;
  logic [POS_BITS-1:0]     r_pos_y;
  logic                    r_overflow;
  logic [DELTA_BITS_X-1:0] r_acc_x;
  logic [DELTA_BITS_Y-1:0] r_acc_y;
  logic [DELTA_BITS_X-1:0] r_delta_x;
  logic [DELTA_BITS_Y-1:0] r_delta_y;
  logic [CNT_BITS-1:0]     r_idle_cnt;
  state_t                  r_state;
  logic                    r_pending;
  logic                    r_report_valid;
  logic                    r_busy;

  logic                    w_ev_x;
  logic                    w_ev_y;
  logic                    w_ev_any;
  logic [POS_BITS:0]       w_pos_x_res;
  logic [POS_BITS:0]       w_pos_y_res;
  logic [DELTA_BITS_X-1:0] w_acc_x_nxt;
  logic [DELTA_BITS_Y-1:0] w_acc_y_nxt;
  logic [DELTA_BITS_X-1:0] w_acc_x_fresh;
  logic [DELTA_BITS_Y-1:0] w_acc_y_fresh;

  // Rising-edge detection and next-value arithmetic for both axes.
  always_comb begin
    w_ev_x      = step_x & ~r_step_x_prev;
    w_ev_y      = step_y & ~r_step_y_prev;
    w_ev_any    = w_ev_x | w_ev_y;
    w_pos_x_res = pos_step(r_pos_x, dir_x);
    w_pos_y_res = pos_step(r_pos_y, dir_y);
    if (w_ev_x) begin
      w_acc_x_nxt   = dx_step(r_acc_x, dir_x);
      w_acc_x_fresh = dx_step({DELTA_BITS_X{1'b0}}, dir_x);
    end else begin
      w_acc_x_nxt   = r_acc_x;
      w_acc_x_fresh = {DELTA_BITS_X{1'b0}};
    end
    if (w_ev_y) begin
      w_acc_y_nxt   = dy_step(r_acc_y, dir_y);
      w_acc_y_fresh = dy_step({DELTA_BITS_Y{1'b0}}, dir_y);
    end else begin
      w_acc_y_nxt   = r_acc_y;
      w_acc_y_fresh = {DELTA_BITS_Y{1'b0}};
    end
  end

  // Step history, sampled every clk regardless of clk_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_x_prev <= 1'b0;
      r_step_y_prev <= 1'b0;
    end else begin
      r_step_x_prev <= step_x;
      r_step_y_prev <= step_y;
    end
  end

  // Absolute positions and sticky overflow; clear beats a same-cycle step.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_pos_x    <= {POS_BITS{1'b0}};
      r_pos_y    <= {POS_BITS{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_ev_x) r_pos_x <= w_pos_x_res[POS_BITS-1:0];
      if (w_ev_y) r_pos_y <= w_pos_y_res[POS_BITS-1:0];
      r_overflow <= r_overflow | (w_ev_x & w_pos_x_res[POS_BITS]) | (w_ev_y & w_pos_y_res[POS_BITS]);
    end
  end

  // Move FSM: accumulates net steps, times out on inactivity, holds the report until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_acc_x        <= {DELTA_BITS_X{1'b0}};
      r_acc_y        <= {DELTA_BITS_Y{1'b0}};
      r_delta_x      <= {DELTA_BITS_X{1'b0}};
      r_delta_y      <= {DELTA_BITS_Y{1'b0}};
      r_idle_cnt     <= {CNT_BITS{1'b0}};
      r_pending      <= 1'b0;
      r_report_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_acc_x <= w_acc_x_nxt;
          r_acc_y <= w_acc_y_nxt;
          if (w_ev_any) begin
            r_state    <= ST_MOVING;
            r_idle_cnt <= {CNT_BITS{1'b0}};
            r_busy     <= 1'b1;
          end
        end
        ST_MOVING: begin
          if (r_idle_cnt == IDLE_LIMIT) begin
            // Capture cycle: latch the finished move, restart accumulation.
            r_delta_x      <= r_acc_x;
            r_delta_y      <= r_acc_y;
            r_acc_x        <= w_acc_x_fresh;
            r_acc_y        <= w_acc_y_fresh;
            r_pending      <= w_ev_any;
            r_idle_cnt     <= {CNT_BITS{1'b0}};
            r_report_valid <= 1'b1;
            r_state        <= ST_REPORT;
          end else begin
            r_acc_x <= w_acc_x_nxt;
            r_acc_y <= w_acc_y_nxt;
            if (w_ev_any)    r_idle_cnt <= {CNT_BITS{1'b0}};
            else if (clk_en) r_idle_cnt <= r_idle_cnt + CNT_ONE;
          end
        end
        ST_REPORT: begin
          r_acc_x <= w_acc_x_nxt;
          r_acc_y <= w_acc_y_nxt;
          if (report_ready) begin
            r_report_valid <= 1'b0;
            r_pending      <= 1'b0;
            r_idle_cnt     <= {CNT_BITS{1'b0}};
            // A step landing in the handshake cycle also starts a new move.
            if (r_pending || w_ev_any) begin
              r_state <= ST_MOVING;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_ev_any) begin
            r_pending <= 1'b1;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_idle_cnt     <= {CNT_BITS{1'b0}};
          r_pending      <= 1'b0;
          r_report_valid <= 1'b0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  assign pos_x        = r_pos_x;
  assign pos_y        = r_pos_y;
  assign overflow     = r_overflow;
  assign busy         = r_busy;
  assign report_valid = r_report_valid;
  assign delta_x      = r_delta_x;
  assign delta_y      = r_delta_y;

endmodule
